// File: rtl/instr_fetch.sv
// Instruction fetch unit: single-outstanding memory requests into a 2-entry {instr, pc} FIFO.
// Optional macro INSTR_FETCH_STAT_EN adds a 16-bit pushed-word counter (fetch_count).
module instr_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [23:0] imem_rdata,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        instr_valid,
    output logic [23:0] instr_out,
    output logic [15:0] instr_pc,
    input  logic        ir_ready
`ifdef INSTR_FETCH_STAT_EN
    ,
    output logic [15:0] fetch_count
`endif
);

    logic        req_q, req_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] fetch_pc_q, fetch_pc_d;
    logic        drop_q, drop_d;
    logic [1:0]  count_q, count_d;
    logic [1:0]  count_mid;
    logic [23:0] e0_instr_q, e0_instr_d;
    logic [15:0] e0_pc_q, e0_pc_d;
    logic [23:0] e1_instr_q, e1_instr_d;
    logic [15:0] e1_pc_q, e1_pc_d;
    logic        ack_v;
    logic        push;
    logic        pop;
    logic        outstanding;

    assign instr_valid = (count_q != 2'd0);
    assign instr_out   = e0_instr_q;
    assign instr_pc    = e0_pc_q;
    assign imem_req    = req_q;
    assign imem_addr   = addr_q;

    // Next-state: FIFO shift/fill, drop tracking, request issue
    always_comb begin
        ack_v       = imem_ack && req_q;
        push        = ack_v && !drop_q && !redirect;
        pop         = instr_valid && ir_ready && !redirect;
        outstanding = req_q && !imem_ack;

        e0_instr_d = pop ? e1_instr_q : e0_instr_q;
        e0_pc_d    = pop ? e1_pc_q : e0_pc_q;
        e1_instr_d = e1_instr_q;
        e1_pc_d    = e1_pc_q;
        count_mid  = count_q - {1'b0, pop};
        if (push) begin
            if (count_mid == 2'd0) begin
                e0_instr_d = imem_rdata;
                e0_pc_d    = addr_q;
            end else begin
                e1_instr_d = imem_rdata;
                e1_pc_d    = addr_q;
            end
        end

        if (redirect) begin
            count_d    = 2'd0;
            fetch_pc_d = redirect_pc;
            // An in-flight request must complete before its word can be ignored
            drop_d     = outstanding;
        end else begin
            count_d    = count_mid + {1'b0, push};
            fetch_pc_d = fetch_pc_q + {15'd0, push};
            drop_d     = drop_q && !ack_v;
        end

        req_d  = outstanding ? 1'b1 : (count_d != 2'd2);
        addr_d = (!outstanding && req_d) ? fetch_pc_d : addr_q;
    end

    // State registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_q      <= 1'b0;
            addr_q     <= RESET_PC;
            fetch_pc_q <= RESET_PC;
            drop_q     <= 1'b0;
            count_q    <= 2'd0;
            e0_instr_q <= 24'h0;
            e0_pc_q    <= 16'h0;
            e1_instr_q <= 24'h0;
            e1_pc_q    <= 16'h0;
        end else begin
            req_q      <= req_d;
            addr_q     <= addr_d;
            fetch_pc_q <= fetch_pc_d;
            drop_q     <= drop_d;
            count_q    <= count_d;
            e0_instr_q <= e0_instr_d;
            e0_pc_q    <= e0_pc_d;
            e1_instr_q <= e1_instr_d;
            e1_pc_q    <= e1_pc_d;
        end
    end

`ifdef INSTR_FETCH_STAT_EN
    logic [15:0] fetch_count_q, fetch_count_d;

    assign fetch_count = fetch_count_q;

    // Count accepted words; redirects do not clear it
    always_comb begin
        fetch_count_d = fetch_count_q + {15'd0, push};
    end

    // Statistic register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_count_q <= 16'h0;
        end else begin
            fetch_count_q <= fetch_count_d;
        end
    end
`endif

endmodule
